// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec
//
// Multi-cycle execute stage placed directly after the 4x16 register file. A
// start strobe captures the two read operands and the opcode. The selected
// operation is computed, and the result is returned with a one-cycle write
// pulse. That pulse feeds the register file's write_data/write inputs.
//
// ADD/SUB/AND/OR/XOR finish in one cycle. SHL/SHR step one bit per cycle.
// MUL is a shift-add multiplier that handles one multiplier bit per cycle.
//
// Build option:
//   ALU_MUL_EN  defined   -> iterative multiplier compiled in (op 111 = MUL)
//               undefined -> no multiplier; op 111 completes in one cycle with
//                            result 0 and illegal set
//
// Ports:
//   clk      in   1      clock, all state changes on rising edge
//   reset    in   1      synchronous active-high reset
//   start    in   1      request strobe, accepted only when idle
//   op       in   3      opcode, captured with start
//   a        in   WIDTH  operand A (register file data1)
//   b        in   WIDTH  operand B (register file data2)
//   busy     out  1      state is not IDLE
//   done     out  1      one-cycle completion pulse
//   write    out  1      register file write enable, identical to done
//   result   out  WIDTH  last completed result, held until next completion
//   zero     out  1      result == 0
//   illegal  out  1      last completion was a disabled opcode
// -----------------------------------------------------------------------------
module alu_exec #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             write,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    // The counter must hold both a full shift amount and the multiply length.
    localparam int CNT_W = ($clog2(WIDTH + 1) > SHAMT_W + 1) ?
                           $clog2(WIDTH + 1) : SHAMT_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
`ifdef ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'd7;
`endif

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;      // shift value, or the running product
    logic             r_shl;      // direction of the shift in flight
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;
`ifdef ALU_MUL_EN
    logic             r_mul;
    logic [WIDTH-1:0] r_mcand;    // multiplicand, moves left each iteration
    logic [WIDTH-1:0] r_mplier;   // multiplier, moves right each iteration
`endif

    logic [WIDTH-1:0] w_single_res;
    logic             w_single_ill;
    logic [WIDTH-1:0] w_step;
    logic             w_is_shift;
    logic [CNT_W-1:0] w_shamt;

    assign w_shamt    = CNT_W'(b[SHAMT_W-1:0]);
    assign w_is_shift = (op == OP_SHL) || (op == OP_SHR);

    // Result of any op that completes straight from IDLE. A shift only takes
    // this path when its count is zero, so its result is simply a.
    always_comb begin
        // NOTE: defaults first so that every path assigns every output and no latch is inferred.
        w_single_res = '0;
        w_single_ill = 1'b0;
        case (op)
            OP_ADD:         w_single_res = a + b;
            OP_SUB:         w_single_res = a - b;
            OP_AND:         w_single_res = a & b;
            OP_OR:          w_single_res = a | b;
            OP_XOR:         w_single_res = a ^ b;
            OP_SHL, OP_SHR: w_single_res = a;
            default: begin
`ifndef ALU_MUL_EN
                w_single_ill = 1'b1;
`endif
            end
        endcase
    end

    // Next value of the accumulator for one RUN iteration.
    always_comb begin
        w_step = r_shl ? (r_acc << 1) : (r_acc >> 1);
`ifdef ALU_MUL_EN
        if (r_mul) begin
            w_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: every register here has a small, defined reset value. A reset during an
        // operation must abort it and clear result, so no register is left without reset.
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_shl     <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
`ifdef ALU_MUL_EN
            r_mul     <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so all state updates together at the edge.
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_state <= S_RUN;
                            r_cnt   <= w_shamt;
                            r_acc   <= a;
                            r_shl   <= (op == OP_SHL);
`ifdef ALU_MUL_EN
                            r_mul   <= 1'b0;
`endif
                        end
`ifdef ALU_MUL_EN
                        else if (op == OP_MUL) begin
                            r_state  <= S_RUN;
                            r_cnt    <= CNT_W'(WIDTH);
                            r_acc    <= '0;
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_mul    <= 1'b1;
                        end
`endif
                        else begin
                            r_state   <= S_DONE;
                            r_result  <= w_single_res;
                            r_zero    <= (w_single_res == '0);
                            r_illegal <= w_single_ill;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - 1'b1;
`ifdef ALU_MUL_EN
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
`endif
                    // The last iteration writes the result on the same edge as
                    // the move to DONE, so result is valid while done is high.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state   <= S_DONE;
                        r_result  <= w_step;
                        r_zero    <= (w_step == '0);
                        r_illegal <= 1'b0;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Every output is decoded from registers only. No input reaches an output
    // combinationally.
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign write   = (r_state == S_DONE);
    assign result  = r_result;
    assign zero    = r_zero;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_alu_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_exec
//
// Self-checking bench for alu_exec. Expected results, flags and latencies come
// from an arithmetic reference model that applies the opcode rules directly.
// Set ALU_MUL_EN the same way as for the RTL build.
// -----------------------------------------------------------------------------
module tb_alu_exec;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic        write;
    logic [15:0] result;
    logic        zero;
    logic        illegal;

    int total = 0;
    int bad   = 0;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_exec #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .write   (write),
        .result  (result),
        .zero    (zero),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_result(input logic [2:0] f_op,
                                               input logic [15:0] f_a,
                                               input logic [15:0] f_b);
        int unsigned ua = f_a;
        int unsigned ub = f_b;
        int unsigned sh = f_b[3:0];
        int unsigned r;
        case (f_op)
            3'd0:    r = (ua + ub) % 65536;
            3'd1:    r = (ua + 65536 - ub) % 65536;
            3'd2:    r = ua & ub;
            3'd3:    r = ua | ub;
            3'd4:    r = ua ^ ub;
            3'd5:    r = (ua << sh) % 65536;
            3'd6:    r = ua >> sh;
            default: r = MUL_EN ? (ua * ub) % 65536 : 0;
        endcase
        return 16'(r);
    endfunction

    function automatic int ref_latency(input logic [2:0] f_op, input logic [15:0] f_b);
        int sh = int'(f_b[3:0]);
        if (f_op == 3'd5 || f_op == 3'd6) return 1 + sh;
        if (f_op == 3'd7)                 return MUL_EN ? 17 : 1;
        return 1;
    endfunction

    function automatic logic ref_illegal(input logic [2:0] f_op);
        return (f_op == 3'd7) && !MUL_EN;
    endfunction

    // ---------------- stimulus driver ----------------
    // Issues one operation and waits, with a bound, for done. The operands are
    // scrambled right after the accepting edge so the bench sees whether the
    // DUT really captured them. Latency k means done was seen at the k-th
    // falling edge after the accepting rising edge. lat = -1 means a timeout.
    task automatic do_op(input  logic [2:0]  t_op,
                         input  logic [15:0] t_a,
                         input  logic [15:0] t_b,
                         output int          lat,
                         output logic [15:0] res,
                         output logic        z,
                         output logic        ill,
                         output logic        wr,
                         output int          writes,
                         output logic        busy_after,
                         output logic        done_after);
        @(negedge clk);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        lat = -1; res = '0; z = 1'b0; ill = 1'b0; wr = 1'b0; writes = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (write) writes++;
            if (k == 1) begin
                start = 1'b0;
                op    = 3'($urandom);
                a     = 16'($urandom);
                b     = 16'($urandom);
            end
            if (done) begin
                lat = k; res = result; z = zero; ill = illegal; wr = write;
                break;
            end
        end
        @(negedge clk);
        if (write) writes++;
        busy_after = busy;
        done_after = done;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (write !== 1'b0)   begin bad++; $display("FAIL reset_write: got %b want 0", write); end
        total++; if (result !== 16'h0) begin bad++; $display("FAIL reset_result: got %h want 0000", result); end
        total++; if (zero !== 1'b1)    begin bad++; $display("FAIL reset_zero: got %b want 1", zero); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b want 0", illegal); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Directed single operation, checked against the model in every respect.
    task automatic test_directed(input string name, input logic [2:0] t_op,
                                 input logic [15:0] t_a, input logic [15:0] t_b);
        int lat, writes;
        logic [15:0] res, exp_res;
        logic z, ill, wr, ba, da;
        exp_res = ref_result(t_op, t_a, t_b);
        do_op(t_op, t_a, t_b, lat, res, z, ill, wr, writes, ba, da);
        total++; if (lat !== ref_latency(t_op, t_b))
            begin bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, ref_latency(t_op, t_b)); end
        total++; if (res !== exp_res)
            begin bad++; $display("FAIL %s result: got %h want %h", name, res, exp_res); end
        total++; if (z !== (exp_res == 16'h0))
            begin bad++; $display("FAIL %s zero: got %b want %b", name, z, exp_res == 16'h0); end
        total++; if (ill !== ref_illegal(t_op))
            begin bad++; $display("FAIL %s illegal: got %b want %b", name, ill, ref_illegal(t_op)); end
        total++; if (writes !== 1 || wr !== 1'b1)
            begin bad++; $display("FAIL %s write_pulses: got %0d want 1", name, writes); end
        total++; if (ba !== 1'b0 || da !== 1'b0)
            begin bad++; $display("FAIL %s after_done busy/done: got %b%b want 00", name, ba, da); end
        total++; if (result !== exp_res)
            begin bad++; $display("FAIL %s result_held: got %h want %h", name, result, exp_res); end
    endtask

    // Start pulses while the operation is running must be ignored.
    task automatic test_start_ignored();
        logic [2:0]  t_op;
        logic [15:0] t_a, t_b, exp_res, res;
        int lat, writes;
        t_op = MUL_EN ? 3'd7 : 3'd5;
        t_a  = MUL_EN ? 16'h0123 : 16'h0001;
        t_b  = MUL_EN ? 16'h0010 : 16'h000C;
        exp_res = ref_result(t_op, t_a, t_b);
        @(negedge clk);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        lat = -1; writes = 0; res = '0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (write) writes++;
            if (done && lat < 0) begin lat = k; res = result; end
            start = (k >= 2 && k <= 5) ? ((k % 2) == 0) : 1'b0;
            op = 3'd0; a = 16'h0001; b = 16'h0001;
        end
        start = 1'b0;
        total++; if (writes !== 1)
            begin bad++; $display("FAIL ignore_start writes: got %0d want 1", writes); end
        total++; if (lat !== ref_latency(t_op, t_b))
            begin bad++; $display("FAIL ignore_start latency: got %0d want %0d", lat, ref_latency(t_op, t_b)); end
        total++; if (res !== exp_res || result !== exp_res)
            begin bad++; $display("FAIL ignore_start result: got %h/%h want %h", res, result, exp_res); end
    endtask

    // Reset during a shift aborts it: no write, result cleared, idle again.
    task automatic test_reset_abort();
        int writes;
        test_directed("pre_abort_add", 3'd0, 16'h0001, 16'h0002);
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 16'h0003; b = 16'h000A;
        writes = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (write) writes++;
            if (k == 1) start = 1'b0;
            if (k == 4) reset = 1'b1;
        end
        @(negedge clk);
        if (write) writes++;
        total++; if (writes !== 0)     begin bad++; $display("FAIL abort_writes: got %0d want 0", writes); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (result !== 16'h0) begin bad++; $display("FAIL abort_result: got %h want 0000", result); end
        total++; if (zero !== 1'b1)    begin bad++; $display("FAIL abort_zero: got %b want 1", zero); end
        reset = 1'b0;
        test_directed("post_abort_add", 3'd0, 16'h1234, 16'h0001);
    endtask

    // start held high: an ADD is accepted every second cycle.
    task automatic test_back_to_back();
        logic [15:0] vals [7];
        logic [15:0] exp_res;
        for (int i = 0; i < 7; i++) vals[i] = 16'($urandom);
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++; if (done !== (i % 2 == 1))
                    begin bad++; $display("FAIL b2b_done[%0d]: got %b want %b", i, done, i % 2 == 1); end
                if (i % 2 == 1) begin
                    exp_res = ref_result(3'd0, vals[i-1], 16'h0101);
                    total++; if (result !== exp_res)
                        begin bad++; $display("FAIL b2b_result[%0d]: got %h want %h", i, result, exp_res); end
                end
            end
            if (i < 6) begin start = 1'b1; op = 3'd0; a = vals[i]; b = 16'h0101; end
            else start = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat, writes;
        logic [2:0]  r_op;
        logic [15:0] ra, rb, res, exp_res;
        logic z, ill, wr, ba, da;
        for (int n = 0; n < 40; n++) begin
            r_op = 3'($urandom_range(0, 7));
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            if (n % 8 == 0) rb[3:0] = 4'h0;
            exp_res = ref_result(r_op, ra, rb);
            do_op(r_op, ra, rb, lat, res, z, ill, wr, writes, ba, da);
            total++;
            if (lat !== ref_latency(r_op, rb) || res !== exp_res || z !== (exp_res == 16'h0) ||
                ill !== ref_illegal(r_op) || writes !== 1 || ba !== 1'b0 || da !== 1'b0) begin
                bad++;
                $display("FAIL random op=%0d a=%h b=%h: got lat=%0d res=%h z=%b ill=%b wr=%0d want lat=%0d res=%h z=%b ill=%b wr=1",
                         r_op, ra, rb, lat, res, z, ill, writes,
                         ref_latency(r_op, rb), exp_res, exp_res == 16'h0, ref_illegal(r_op));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed("add_wrap",  3'd0, 16'hFFFF, 16'h0001);
        test_directed("sub_neg",   3'd1, 16'h0005, 16'h0007);
        test_directed("and",       3'd2, 16'hF0F0, 16'h3C3C);
        test_directed("or",        3'd3, 16'hF000, 16'h000F);
        test_directed("xor",       3'd4, 16'hAAAA, 16'hFFFF);
        test_directed("shl_15",    3'd5, 16'h0001, 16'h000F);
        test_directed("shr_0",     3'd6, 16'hBEEF, 16'h0000);
        test_directed("shr_4",     3'd6, 16'h8421, 16'h0004);
        test_directed("mul_1230",  3'd7, 16'h0123, 16'h0010);
        test_directed("add_clear_illegal", 3'd0, 16'h0002, 16'h0003);
        test_directed("mul_wrap0", 3'd7, 16'h0100, 16'h0100);
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle execute stage sitting directly downstream of the 4x16 register file. It latches the two read operands (`data1`, `data2`) on a start strobe, computes the selected 16-bit operation and returns the result with a one-cycle `write` pulse that drives the register file's `write_data` and `write` inputs. Add, subtract and the logic ops take one cycle. Shifts and multiply are iterative.

## Interface
Parameters:
- `WIDTH`, 16: datapath width. Must match the register file word.
- `SHAMT_W`, 4: shift-amount bits taken from `b[SHAMT_W-1:0]`.

Ports:
- `clk`  in  1  Single clock; all state updates on its rising edge.
- `reset`  in  1  Synchronous, active-high reset. Sampled on the rising edge of `clk`.
- `start`  in  1  Request strobe. Accepted only in IDLE.
- `op`  in  3  Opcode, sampled with `start`.
- `a`  in  WIDTH  Operand A, from register file `data1`.
- `b`  in  WIDTH  Operand B, from register file `data2`.
- `busy`  out  1  High whenever the state is not IDLE.
- `done`  out  1  One-cycle completion pulse.
- `write`  out  1  Register-file write enable. Identical to `done`.
- `result`  out  WIDTH  Last completed result. Held until the next completion.
- `zero`  out  1  `result == 0`.
- `illegal`  out  1  Set on completion of a disabled opcode. Cleared on the next completion.

## Operation
- Opcodes:
  - 000 ADD: `a+b`
  - 001 SUB: `a-b`
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL: logical left by `b[3:0]`
  - 110 SHR: logical right by `b[3:0]`
  - 111 MUL: low 16 bits of `a*b`, shift-add, one bit per cycle
- Arithmetic is modulo 2^16. Carry and overflow are discarded.
- `a`, `b` and `op` are captured on the accepting edge. Later changes to the register file outputs do not affect an operation in flight.
- FSM states: IDLE, RUN, DONE.
  - IDLE with `start`=1 and a single-cycle op (000–100) → DONE.
  - IDLE with `start`=1 and a shift with count 0 → DONE, result = `a`.
  - IDLE with `start`=1 and a shift with nonzero count n → RUN, counter = n.
  - IDLE with `start`=1 and MUL → RUN, counter = 16.
  - RUN: one shift step (or one multiply iteration) per cycle, counter decrements. Transition to DONE on the cycle the counter reaches 0.
  - DONE → IDLE unconditionally. In DONE, `done`=`write`=1, and `result`, `zero` and `illegal` update.
- `start` in RUN or DONE is ignored: no queueing, no error.
- Reset mid-operation aborts the operation. No `write` pulse is produced, and `result` is cleared.

## Timing
- Reset values: IDLE, `busy`=0, `done`=0, `write`=0, `result`=0, `zero`=1, `illegal`=0.
- Start accepted at edge t:
  - Single-cycle op: `done` is high in cycle t+1.
  - Shift by n: `done` is high in cycle t+1+n.
  - MUL: `done` is high in cycle t+17.
- `busy` rises in the cycle after acceptance and falls in the cycle after `done`.
- Maximum issue rate is one start every 2 cycles (single-cycle ops).
- Outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `ALU_MUL_EN` defined: the iterative multiplier is compiled in, and op 111 behaves as above.
- `ALU_MUL_EN` undefined: no multiplier hardware. Op 111 completes as a single-cycle op with `result`=0, `write`=1 and `illegal`=1. All other ops are unchanged.

## Test plan
- Reset, then ADD with a=0xFFFF, b=0x0001 → `done`/`write` in cycle t+1, `result`=0x0000, `zero`=1.
- SUB with a=0x0005, b=0x0007 → `result`=0xFFFE after 1 cycle. Toggle `a`/`b` after the accepting edge → no effect on `result`.
- SHL with a=0x0001, b=0x000F → `done` at t+16, `result`=0x8000. SHR with b=0 → `done` at t+1, `result`=a.
- MUL with a=0x0123, b=0x0010 → `done` at t+17, `result`=0x1230. Pulse `start` during RUN → ignored, exactly one `write` pulse.
- MUL with a=0x0100, b=0x0100 → `result`=0x0000, `zero`=1. Without `ALU_MUL_EN` → `done` at t+1, `illegal`=1, `result`=0.
- Start SHL by 10, assert `reset` at t+4 → no `write` pulse, `busy`=0 and `result`=0 on the next cycle, and a new ADD is then accepted normally.
